// File: rtl/gray_sched_pkg.sv
// Shared encodings for the gray_sched controller: FSM state codes, default
// step-field width and a Gray-encode helper used by the bench model.
package gray_sched_pkg;

  localparam int STEP_W_DEFAULT = 4;

  localparam logic [2:0] INIT   = 3'd0;
  localparam logic [2:0] IDLE   = 3'd1;
  localparam logic [2:0] RUN    = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] CLEAR  = 3'd4;

  function automatic logic [2:0] gray3(input logic [2:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. Grants are combinational and one-hot; the
// pointer remembers who won last so simultaneous requests alternate.
module rr_arb2
  import gray_sched_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_gnt;  // 1 = requester 1 won most recently, so requester 0 is favoured

  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_gnt <= 1'b1;
    end else if (|gnt) begin
      last_gnt <= gnt[1];
    end
  end

endmodule

// File: rtl/gray_sched.sv
// Controller and two-port round-robin scheduler in front of a 3-bit Gray
// counter: grants one run of N enable steps at a time and returns the result.
module gray_sched
  import gray_sched_pkg::*;
#(
  parameter int STEP_W   = STEP_W_DEFAULT,
  parameter bit AUTO_CLR = 1'b1
)(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic [STEP_W-1:0] Steps0,
  input  logic              Req1,
  input  logic [STEP_W-1:0] Steps1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              Done0,
  output logic              Done1,
  output logic [2:0]        Result,
  output logic              ResultOvf,
  output logic              Busy,
  output logic              CntEn,
  output logic              CntReset,
  input  logic [2:0]        GrayIn,
  input  logic              OvfIn
);

  logic [2:0]        state;
  logic [STEP_W-1:0] remaining;
  logic              owner;
  logic [1:0]        gnt;
  logic              arb_en;
  logic [STEP_W-1:0] grant_steps;

  // Grants are suppressed while Reset is high even if the state still reads IDLE.
  assign arb_en = (state == IDLE) && !Reset;

  rr_arb2 u_arb (
    .Clk   (Clk),
    .Reset (Reset),
    .req   ({Req1, Req0}),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign Gnt0        = gnt[0];
  assign Gnt1        = gnt[1];
  assign grant_steps = gnt[1] ? Steps1 : Steps0;

  assign CntEn    = (state == RUN);
  assign CntReset = Reset || (state == INIT) || (state == CLEAR);
  assign Busy     = (state != IDLE);

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments throughout so every register reads pre-edge values.
    if (Reset) begin
      state     <= INIT;
      remaining <= '0;
      owner     <= 1'b0;
      Done0     <= 1'b0;
      Done1     <= 1'b0;
      Result    <= 3'b000;
      ResultOvf <= 1'b0;
    end else begin
      Done0 <= 1'b0;
      Done1 <= 1'b0;
      case (state)
        INIT: state <= IDLE;
        IDLE: begin
          if (|gnt) begin
            owner     <= gnt[1];
            remaining <= grant_steps;
            state     <= (grant_steps == '0) ? SETTLE : RUN;
          end
        end
        RUN: begin
          remaining <= remaining - STEP_W'(1);
          if (remaining == STEP_W'(1)) begin
            state <= SETTLE;
          end
        end
        SETTLE: begin
          Result    <= GrayIn;
          ResultOvf <= OvfIn;
          Done0     <= !owner;
          Done1     <= owner;
          state     <= (AUTO_CLR && OvfIn) ? CLEAR : IDLE;
        end
        CLEAR:   state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_sched.sv
// Bench for gray_sched: a counter model closes the loop, a run-schedule model
// predicts every output each cycle, and directed runs pin literal results.
`timescale 1ns/1ps
module tb_gray_sched;
  import gray_sched_pkg::gray3;

  localparam int STEP_W   = 4;
  localparam bit AUTO_CLR = 1'b1;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              Req0 = 1'b0, Req1 = 1'b0;
  logic [STEP_W-1:0] Steps0 = '0, Steps1 = '0;
  logic              Gnt0, Gnt1, Done0, Done1, ResultOvf, Busy, CntEn, CntReset, OvfIn;
  logic [2:0]        Result, GrayIn;

  gray_sched #(.STEP_W(STEP_W), .AUTO_CLR(AUTO_CLR)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Req0      (Req0),
    .Steps0    (Steps0),
    .Req1      (Req1),
    .Steps1    (Steps1),
    .Gnt0      (Gnt0),
    .Gnt1      (Gnt1),
    .Done0     (Done0),
    .Done1     (Done1),
    .Result    (Result),
    .ResultOvf (ResultOvf),
    .Busy      (Busy),
    .CntEn     (CntEn),
    .CntReset  (CntReset),
    .GrayIn    (GrayIn),
    .OvfIn     (OvfIn)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Counter the block controls: binary count with Gray output and sticky wrap flag.
  logic [2:0] cnt_bin;
  logic       cnt_ovf;
  always @(posedge Clk) begin
    if (CntReset) begin
      cnt_bin <= 3'd0;
      cnt_ovf <= 1'b0;
    end else if (CntEn) begin
      cnt_bin <= cnt_bin + 3'd1;
      if (cnt_bin == 3'd7) cnt_ovf <= 1'b1;
    end
  end
  assign GrayIn = gray3(cnt_bin);
  assign OvfIn  = cnt_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Schedule model: each grant books its enable window, finish cycle and result.
  bit         m_rst_prev = 1'b0;
  bit         m_active   = 1'b0;
  int         m_g = 0, m_n = 0, m_owner = 0, m_last = 1, m_cnt = 0;
  bit         m_ovf = 1'b0, m_clr = 1'b0, m_run_ovf = 1'b0, m_rovf = 1'b0;
  logic [2:0] m_run_res = 3'b000, m_res = 3'b000;

  always @(negedge Clk) begin : model
    bit         init, fin, idle, e_en, e_clr;
    int         end_val;
    logic [1:0] e_gnt;
    if (Reset) begin
      check("rst_gnt0", 32'(Gnt0), 0);
      check("rst_gnt1", 32'(Gnt1), 0);
      check("rst_cntreset", 32'(CntReset), 1);
      if (m_rst_prev) begin
        check("rst_busy", 32'(Busy), 1);
        check("rst_cnten", 32'(CntEn), 0);
        check("rst_done0", 32'(Done0), 0);
        check("rst_done1", 32'(Done1), 0);
        check("rst_result", 32'(Result), 0);
        check("rst_resultovf", 32'(ResultOvf), 0);
      end
      m_active = 1'b0; m_cnt = 0; m_ovf = 1'b0; m_last = 1;
      m_res = 3'b000; m_rovf = 1'b0; m_rst_prev = 1'b1;
    end else begin
      init = m_rst_prev;
      m_rst_prev = 1'b0;
      fin   = m_active && (cyc == m_g + m_n + 2);
      e_en  = m_active && (cyc > m_g) && (cyc <= m_g + m_n);
      e_clr = fin && m_clr;
      if (fin) begin
        m_res  = m_run_res;
        m_rovf = m_run_ovf;
      end
      idle  = !init && (!m_active || cyc >= m_g + m_n + 2 + int'(m_clr));
      e_gnt = 2'b00;
      if (idle) begin
        if (Req0 && Req1) e_gnt = (m_last == 1) ? 2'b01 : 2'b10;
        else              e_gnt = {Req1, Req0};
      end
      check("gnt0", 32'(Gnt0), 32'(e_gnt[0]));
      check("gnt1", 32'(Gnt1), 32'(e_gnt[1]));
      check("cnten", 32'(CntEn), 32'(e_en));
      check("cntreset", 32'(CntReset), 32'(init || e_clr));
      check("busy", 32'(Busy), 32'(!idle));
      check("done0", 32'(Done0), 32'(fin && m_owner == 0));
      check("done1", 32'(Done1), 32'(fin && m_owner == 1));
      check("result", 32'(Result), 32'(m_res));
      check("resultovf", 32'(ResultOvf), 32'(m_rovf));
      if (e_gnt != 2'b00) begin
        m_owner   = e_gnt[1] ? 1 : 0;
        m_last    = m_owner;
        m_n       = (m_owner == 1) ? int'(Steps1) : int'(Steps0);
        m_g       = cyc;
        m_active  = 1'b1;
        end_val   = m_cnt + m_n;
        m_run_ovf = m_ovf || (end_val >= 8);
        m_run_res = gray3(3'(end_val % 8));
        m_clr     = AUTO_CLR && m_run_ovf;
        if (m_clr) begin
          m_cnt = 0;
          m_ovf = 1'b0;
        end else begin
          m_cnt = end_val % 8;
          m_ovf = m_run_ovf;
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Leaves the bench at the drive point of the INIT cycle.
  task automatic do_reset();
    Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic at_neg(input int c);
    @(negedge Clk);
    while (cyc < c) @(negedge Clk);
  endtask

  // One requested run with literal expectations; starts and ends at a drive point.
  task automatic run_req(input int k, input int n, input logic [2:0] er,
                         input logic eo, input logic ec, input string nm);
    int g;
    bit seen;
    g = 0;
    seen = 1'b0;
    if (k == 0) begin Req0 = 1'b1; Steps0 = STEP_W'(n); end
    else        begin Req1 = 1'b1; Steps1 = STEP_W'(n); end
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if ((k == 0) ? Gnt0 : Gnt1) begin seen = 1'b1; g = cyc; break; end
      tick();
    end
    check({nm, "_grant"}, 32'(seen), 1);
    tick();
    Req0 = 1'b0;
    Req1 = 1'b0;
    if (!seen) return;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if ((k == 0) ? Done0 : Done1) begin seen = 1'b1; break; end
    end
    check({nm, "_done_seen"}, 32'(seen), 1);
    check({nm, "_latency"}, 32'(cyc - g), 32'(n + 2));
    check({nm, "_result"}, 32'(Result), 32'(er));
    check({nm, "_resultovf"}, 32'(ResultOvf), 32'(eo));
    check({nm, "_cntreset"}, 32'(CntReset), 32'(ec));
    tick();
  endtask

  function automatic logic [STEP_W-1:0] rand_steps();
    if ($urandom_range(0, 3) == 0) return STEP_W'($urandom_range(0, 15));
    return STEP_W'($urandom_range(0, 4));
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int g, rst_left;
    bit hold0, hold1, seen0, seen1;
    tick();

    // Reset release with no traffic: one INIT cycle, then idle.
    do_reset();
    @(negedge Clk);
    check("t1_init_cntreset", 32'(CntReset), 1);
    check("t1_init_busy", 32'(Busy), 1);
    tick();
    @(negedge Clk);
    check("t1_idle_cntreset", 32'(CntReset), 0);
    check("t1_idle_busy", 32'(Busy), 0);
    repeat (3) tick();

    // Three steps from zero.
    run_req(0, 3, 3'b010, 1'b0, 1'b0, "t2");

    // Simultaneous requests alternate; second grant lands on the Done0 cycle.
    do_reset();
    tick();
    Req0 = 1'b1; Req1 = 1'b1; Steps0 = 4'd1; Steps1 = 4'd1;
    @(negedge Clk);
    g = cyc;
    check("t3_first_gnt0", 32'(Gnt0), 1);
    check("t3_first_gnt1", 32'(Gnt1), 0);
    tick();
    Req0 = 1'b0;
    at_neg(g + 3);
    check("t3_done0", 32'(Done0), 1);
    check("t3_result0", 32'(Result), 32'(3'b001));
    check("t3_gnt1_with_done0", 32'(Gnt1), 1);
    tick();
    Req1 = 1'b0;
    at_neg(g + 6);
    check("t3_done1", 32'(Done1), 1);
    check("t3_result1", 32'(Result), 32'(3'b011));
    tick();

    // Wrap with automatic clear, then a zero-step run sees the cleared counter.
    do_reset();
    tick();
    run_req(0, 9, 3'b001, 1'b1, 1'b1, "t4_wrap");
    run_req(0, 0, 3'b000, 1'b0, 1'b0, "t4_after_clear");

    // Zero-step run reads the current counter value without enabling it.
    run_req(1, 5, 3'b111, 1'b0, 1'b0, "t5_fill");
    run_req(1, 0, 3'b111, 1'b0, 1'b0, "t5_zero");

    // Reset in the second RUN cycle abandons the run.
    do_reset();
    tick();
    Req0 = 1'b1; Steps0 = 4'd6;
    @(negedge Clk);
    g = cyc;
    check("t6_gnt0", 32'(Gnt0), 1);
    tick();
    Req0 = 1'b0;
    tick();
    Reset = 1'b1;
    @(negedge Clk);
    check("t6_cntreset_in_reset", 32'(CntReset), 1);
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    check("t6_cntreset_init", 32'(CntReset), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge Clk);
      check("t6_no_done0", 32'(Done0), 0);
    end
    tick();
    run_req(0, 2, 3'b011, 1'b0, 1'b0, "t6_after");

    // Random traffic with occasional resets; the model checks every cycle.
    hold0 = 1'b0; hold1 = 1'b0; seen0 = 1'b0; seen1 = 1'b0; rst_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (rst_left > 0) begin
        rst_left--;
        Reset = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        Reset = 1'b1;
        rst_left = int'($urandom_range(0, 2));
      end else begin
        Reset = 1'b0;
      end
      if (seen0) begin hold0 = 1'b0; Req0 = 1'b0; end
      if (seen1) begin hold1 = 1'b0; Req1 = 1'b0; end
      if (!hold0 && $urandom_range(0, 3) == 0) begin
        hold0 = 1'b1; Req0 = 1'b1; Steps0 = rand_steps();
      end
      if (!hold1 && $urandom_range(0, 3) == 0) begin
        hold1 = 1'b1; Req1 = 1'b1; Steps1 = rand_steps();
      end
      @(negedge Clk);
      seen0 = Gnt0;
      seen1 = Gnt1;
      tick();
    end
    Reset = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
